// File: rtl/tse_reg_arbiter_pkg.sv
// Shared types and constants for the MAC register-port arbiter.
package tse_reg_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int MAX_REQ = 4;
    localparam int PTR_W   = 2;

    // Read data returned to a requester whose transfer was aborted on timeout.
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tse_reg_arbiter_if.sv
// Requester command/response bus plus the MAC register port.
interface tse_reg_arbiter_if
    import tse_reg_pkg::*;
#(
    parameter int N_REQ = 3
) ();

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_wr;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    logic [ADDR_W-1:0]            reg_addr;
    logic [DATA_W-1:0]            reg_data_in;
    logic                         reg_rd;
    logic                         reg_wr;
    logic [DATA_W-1:0]            reg_data_out;
    logic                         reg_busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, reg_data_out, reg_busy,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               reg_addr, reg_data_in, reg_rd, reg_wr
    );

    // Requesters and MAC model side.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, reg_data_out, reg_busy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               reg_addr, reg_data_in, reg_rd, reg_wr
    );

endinterface

// File: rtl/tse_reg_arbiter_rr.sv
// Round-robin selector: first active request at or above rr_ptr, wrapping.
module tse_rr_arbiter
    import tse_reg_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan the requesters starting at rr_ptr and take the first one that is active.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tse_reg_arbiter.sv
// Shares one MAC register port among N_REQ requesters, one transfer at a time,
// with a wait-request timeout. Every output comes straight from a flop.
//
// state | meaning
// IDLE  | no transfer; grant the next requester when any is pending
// ISSUE | strobe on the MAC port, waiting for reg_busy low or timeout
// RESP  | transfer finished; post the response and advance rr_ptr
module tse_reg_arbiter
    import tse_reg_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1023
) (
    input logic              clk,
    input logic              rst,
    tse_reg_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q;
    state_t              state_n;
    logic [N_REQ-1:0]    grant;
    logic [MAX_REQ-1:0]  grant_ext;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    gnt_q;
    logic [PTR_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    wait_cnt;
    logic                cmd_wr;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic                take;
    logic                done;
    logic                expire;

    tse_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign grant_ext = MAX_REQ'(grant);
    assign gnt_idx   = onehot_to_idx(grant_ext);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next state plus the one-cycle events that steer the datapath.
    always_comb begin
        state_n = state_q;
        take    = 1'b0;
        done    = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    take    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.reg_busy) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    // This busy cycle is the TIMEOUT-th one: give up.
                    expire  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command latch, MAC strobes, wait counter, response and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q           <= '0;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            cmd_wr          <= 1'b0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            bus.req_ready   <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.reg_addr    <= '0;
            bus.reg_data_in <= '0;
            bus.reg_rd      <= 1'b0;
            bus.reg_wr      <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;

            if (take) begin
                gnt_q           <= gnt_idx;
                cmd_wr          <= bus.req_wr[gnt_idx];
                wait_cnt        <= '0;
                bus.req_ready   <= grant;
                bus.reg_addr    <= bus.req_addr[gnt_idx];
                bus.reg_data_in <= bus.req_wdata[gnt_idx];
                bus.reg_wr      <= bus.req_wr[gnt_idx];
                bus.reg_rd      <= ~bus.req_wr[gnt_idx];
            end

            if (state_q == ISSUE && bus.reg_busy) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (done || expire) begin
                bus.reg_rd      <= 1'b0;
                bus.reg_wr      <= 1'b0;
                bus.reg_addr    <= '0;
                bus.reg_data_in <= '0;
                rsp_err_q       <= expire;
                if (expire)      rsp_data_q <= TIMEOUT_DATA;
                else if (cmd_wr) rsp_data_q <= '0;
                else             rsp_data_q <= bus.reg_data_out;
            end

            if (state_q == RESP) begin
                bus.rsp_valid <= N_REQ'(1) << gnt_q;
                bus.rsp_rdata <= rsp_data_q;
                bus.rsp_err   <= rsp_err_q;
                rr_ptr        <= (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
            end
        end
    end

endmodule
